uart_apb_sequencer: RTL and testbench

APB master that owns the 4-register APB UART core (00 baud-divisor low, 01 baud-divisor high, 10 TX data, 11 RX data) and sequences all accesses to it.
- After reset it programs the baud divisor.
- It then drains a small TX byte queue into register 10 whenever TXRDY allows.
- It reads register 11 whenever RXRDY is raised.
- RX reads take priority over TX writes.

---
 rtl/uart_apb_sequencer.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// Purpose : APB master that configures a 4-register UART core and then moves TX bytes / RX bytes through it.
// Latency : APB transfers are SETUP + ACCESS(>=1) + GAP; rx_valid fires the cycle after the read completes.
// Backpress: tx_ready drops when the TX queue is full; rx_valid has no backpressure; ACCESS aborts after TIMEOUT cycles.
//
// Ports:
//   PCLK, PRESET                       clock, asynchronous active-high reset
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA   APB request towards the UART core (registered)
//   PRDATA/PREADY                      APB response from the UART core
//   TXRDY/RXRDY                        UART status levels
//   cfg_req/cfg_div/cfg_done           divisor reprogramming handshake
//   tx_valid/tx_data/tx_ready          TX byte push interface
//   rx_valid/rx_data                   received byte output
//   err                                one-cycle pulse on PREADY timeout
module uart_apb_sequencer #(
    parameter logic [15:0] BAUD_DIV  = 16'h000D,
    parameter int          TXQ_DEPTH = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [1:0]  PADDR,
    output logic        PWRITE,
    output logic [7:0]  PWDATA,
    input  logic [7:0]  PRDATA,
    input  logic        PREADY,
    input  logic        TXRDY,
    input  logic        RXRDY,
    input  logic        cfg_req,
    input  logic [15:0] cfg_div,
    output logic        cfg_done,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        err
);

    localparam int AW = $clog2(TXQ_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ADDR_DIV_LO = 2'd0;
    localparam logic [1:0] ADDR_DIV_HI = 2'd1;
    localparam logic [1:0] ADDR_TX     = 2'd2;
    localparam logic [1:0] ADDR_RX     = 2'd3;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        SETUP,
        ACCESS,
        GAP
    } state_t;

    // Which kind of transfer is currently on the bus; decides what the
    // completion / abort of ACCESS does.
    typedef enum logic [1:0] {
        OP_CFG_LO,
        OP_CFG_HI,
        OP_RX,
        OP_TX
    } op_t;

    // ------------------------------------------------------------------
    // TX queue: circular buffer, pointers carry one extra wrap bit so that
    // full and empty are told apart by the MSB.
    // ------------------------------------------------------------------
    logic [7:0]  q_mem [TXQ_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        q_full;
    logic        q_empty;
    logic        q_push;
    logic        q_pop;

    assign q_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign q_empty = (wptr_q == rptr_q);
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign q_push  = tx_valid && !q_full;
    assign tx_ready = !q_full;

    // ------------------------------------------------------------------
    // FSM registers
    // ------------------------------------------------------------------
    state_t          state_q;
    state_t          gap_next_q;
    op_t             op_q;
    logic [15:0]     div_q;
    logic [CW-1:0]   cnt_q;
    logic            psel_q;
    logic            penable_q;
    logic [1:0]      paddr_q;
    logic            pwrite_q;
    logic [7:0]      pwdata_q;
    logic            cfg_done_q;
    logic            rx_valid_q;
    logic [7:0]      rx_data_q;
    logic            err_q;
    logic            rx_hold_q;
    logic            tx_hold_q;

    logic            access_done;
    logic            access_tmo;

    assign access_done = (state_q == ACCESS) && PREADY;
    assign access_tmo  = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT - 1));

    // The head byte leaves the queue whether the write completed or was
    // aborted; a timed-out byte is discarded rather than retried.
    assign q_pop = (access_done || access_tmo) && (op_q == OP_TX);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (q_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (q_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (q_push) begin
            q_mem[wptr_q[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= CFG_LO;
            gap_next_q <= IDLE;
            op_q       <= OP_CFG_LO;
            div_q      <= BAUD_DIV;
            cnt_q      <= '0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= 2'd0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 8'h00;
            cfg_done_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            err_q      <= 1'b0;
            rx_hold_q  <= 1'b0;
            tx_hold_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;

            // Hold flags drop on the first low status cycle; a completion
            // in the same cycle re-arms them below (later assignment wins).
            if (!RXRDY) begin
                rx_hold_q <= 1'b0;
            end
            if (!TXRDY) begin
                tx_hold_q <= 1'b0;
            end

            case (state_q)
                CFG_LO: begin
                    op_q     <= OP_CFG_LO;
                    psel_q   <= 1'b1;
                    paddr_q  <= ADDR_DIV_LO;
                    pwrite_q <= 1'b1;
                    pwdata_q <= div_q[7:0];
                    state_q  <= SETUP;
                end

                CFG_HI: begin
                    op_q     <= OP_CFG_HI;
                    psel_q   <= 1'b1;
                    paddr_q  <= ADDR_DIV_HI;
                    pwrite_q <= 1'b1;
                    pwdata_q <= div_q[15:8];
                    state_q  <= SETUP;
                end

                IDLE: begin
                    if (cfg_req) begin
                        div_q      <= cfg_div;
                        cfg_done_q <= 1'b0;
                        state_q    <= CFG_LO;
                    end else if (cfg_done_q && RXRDY && !rx_hold_q) begin
                        op_q     <= OP_RX;
                        psel_q   <= 1'b1;
                        paddr_q  <= ADDR_RX;
                        pwrite_q <= 1'b0;
                        pwdata_q <= 8'h00;
                        state_q  <= SETUP;
                    end else if (cfg_done_q && TXRDY && !tx_hold_q && !q_empty) begin
                        op_q     <= OP_TX;
                        psel_q   <= 1'b1;
                        paddr_q  <= ADDR_TX;
                        pwrite_q <= 1'b1;
                        pwdata_q <= q_mem[rptr_q[AW-1:0]];
                        state_q  <= SETUP;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    if (PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= GAP;
                        case (op_q)
                            OP_CFG_LO: gap_next_q <= CFG_HI;
                            OP_CFG_HI: begin
                                gap_next_q <= IDLE;
                                cfg_done_q <= 1'b1;
                            end
                            OP_RX: begin
                                gap_next_q <= IDLE;
                                rx_data_q  <= PRDATA;
                                rx_valid_q <= 1'b1;
                                rx_hold_q  <= 1'b1;
                            end
                            default: begin
                                gap_next_q <= IDLE;
                                tx_hold_q  <= 1'b1;
                            end
                        endcase
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= GAP;
                        // A failed divisor write restarts the whole pair so
                        // the core never runs on a half-written divisor.
                        if ((op_q == OP_CFG_LO) || (op_q == OP_CFG_HI)) begin
                            gap_next_q <= CFG_LO;
                        end else begin
                            gap_next_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                GAP: begin
                    state_q <= gap_next_q;
                end

                default: begin
                    state_q <= CFG_LO;
                end
            endcase
        end
    end

    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PADDR    = paddr_q;
    assign PWRITE   = pwrite_q;
    assign PWDATA   = pwdata_q;
    assign cfg_done = cfg_done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Purpose : directed bench for uart_apb_sequencer with an event scoreboard.
// Latency : events are compared at the negedge on which they are visible.
// Backpress: every wait is bounded; an expired bound is reported as a failed check.
module tb_uart_apb_sequencer;

    localparam logic [1:0] EV_WR  = 2'd0;
    localparam logic [1:0] EV_RD  = 2'd1;
    localparam logic [1:0] EV_RXV = 2'd2;
    localparam logic [1:0] EV_ERR = 2'd3;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL;
    logic        PENABLE;
    logic [1:0]  PADDR;
    logic        PWRITE;
    logic [7:0]  PWDATA;
    logic [7:0]  PRDATA = 8'h00;
    logic        PREADY = 1'b1;
    logic        TXRDY = 1'b0;
    logic        RXRDY = 1'b0;
    logic        cfg_req = 1'b0;
    logic [15:0] cfg_div = 16'h0000;
    logic        cfg_done;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Expected events: {kind[1:0], addr[1:0], data[7:0]}
    logic [11:0] exp_q [$];

    uart_apb_sequencer dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .TXRDY    (TXRDY),
        .RXRDY    (RXRDY),
        .cfg_req  (cfg_req),
        .cfg_div  (cfg_div),
        .cfg_done (cfg_done),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .err      (err)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [1:0] addr, input logic [7:0] data);
        exp_q.push_back({kind, addr, data});
    endtask

    task automatic observe(input logic [11:0] got);
        logic [11:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %0h expected none", got);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard", {20'd0, got}, {20'd0, e});
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE && PREADY) begin
                observe({PWRITE ? EV_WR : EV_RD, PADDR, PWRITE ? PWDATA : 8'h00});
            end
            if (rx_valid) begin
                observe({EV_RXV, 2'b00, rx_data});
            end
            if (err) begin
                observe({EV_ERR, 2'b00, 8'h00});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        step(6);
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_cfg_done(input string name);
        for (int i = 0; i < 100; i++) begin
            if (cfg_done) break;
            step(1);
        end
        check(name, {31'd0, cfg_done}, 1);
    endtask

    task automatic push(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        step(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        int acc;
        logic seen;
        logic psel_at_err;

        // ---- reset state ----
        step(3);
        check("rst_psel",     {31'd0, PSEL},     0);
        check("rst_penable",  {31'd0, PENABLE},  0);
        check("rst_cfg_done", {31'd0, cfg_done}, 0);
        check("rst_tx_ready", {31'd0, tx_ready}, 1);
        check("rst_rx_valid", {31'd0, rx_valid}, 0);
        check("rst_err",      {31'd0, err},      0);

        // ---- 1: default divisor programming ----
        expect_ev(EV_WR, 2'd0, 8'h0D);
        expect_ev(EV_WR, 2'd1, 8'h00);
        PRESET = 1'b0;
        step(6);
        check("cfg_done_early", {31'd0, cfg_done}, 0);
        step(1);
        check("cfg_done_rise", {31'd0, cfg_done}, 1);
        drain("cfg_default_drain");

        // ---- 2: single TX write, then hold on stale TXRDY ----
        TXRDY = 1'b1;
        expect_ev(EV_WR, 2'd2, 8'h9A);
        push(8'h9A);
        drain("tx_single_drain");
        check("tx_single_empty", {31'd0, tx_ready}, 1);
        push(8'h9B);
        step(10);   // any write here is reported as an unexpected event
        expect_ev(EV_WR, 2'd2, 8'h9B);
        TXRDY = 1'b0;
        step(1);
        TXRDY = 1'b1;
        drain("tx_hold_release_drain");
        TXRDY = 1'b0;
        step(1);

        // ---- 3: RX has priority over a pending TX ----
        push(8'h11);
        expect_ev(EV_RD, 2'd3, 8'h00);
        expect_ev(EV_RXV, 2'd0, 8'h55);
        expect_ev(EV_WR, 2'd2, 8'h11);
        PRDATA = 8'h55;
        RXRDY  = 1'b1;
        TXRDY  = 1'b1;
        drain("rx_prio_drain");
        check("rx_data_held", {24'd0, rx_data}, 32'h55);
        RXRDY = 1'b0;
        TXRDY = 1'b0;
        step(2);

        // ---- 4: fill queue, overflow rejected, ordered drain ----
        for (int i = 0; i < 5; i++) begin
            check("txq_ready_before_push", {31'd0, tx_ready}, (i < 4) ? 1 : 0);
            tx_valid = 1'b1;
            tx_data  = 8'(i + 1);
            step(1);
        end
        tx_valid = 1'b0;
        check("txq_full", {31'd0, tx_ready}, 0);
        for (int i = 1; i <= 4; i++) expect_ev(EV_WR, 2'd2, 8'(i));
        for (int i = 0; i < 4; i++) begin
            TXRDY = 1'b1;
            step(8);
            TXRDY = 1'b0;
            step(1);
        end
        drain("txq_order_drain");
        check("txq_empty_after", {31'd0, tx_ready}, 1);

        // ---- 5: PREADY timeout on a TX write ----
        push(8'h77);
        push(8'h88);
        expect_ev(EV_ERR, 2'd0, 8'h00);
        expect_ev(EV_WR, 2'd2, 8'h88);
        PREADY = 1'b0;
        TXRDY  = 1'b1;
        acc = 0;
        seen = 1'b0;
        psel_at_err = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (err) begin
                seen = 1'b1;
                psel_at_err = PSEL;
                break;
            end
            if (PENABLE) acc++;
        end
        PREADY = 1'b1;
        check("tmo_err_seen", {31'd0, seen}, 1);
        check("tmo_access_cycles", acc, 255);
        check("tmo_psel_low", {31'd0, psel_at_err}, 0);
        drain("tmo_next_byte_drain");
        check("tmo_queue_empty", {31'd0, tx_ready}, 1);
        TXRDY = 1'b0;
        step(2);

        // ---- cfg_req reprogramming keeps queued bytes ----
        push(8'h42);
        expect_ev(EV_WR, 2'd0, 8'h34);
        expect_ev(EV_WR, 2'd1, 8'h12);
        expect_ev(EV_WR, 2'd2, 8'h42);
        cfg_req = 1'b1;
        cfg_div = 16'h1234;
        step(1);
        cfg_req = 1'b0;
        check("cfg_req_clears_done", {31'd0, cfg_done}, 0);
        TXRDY = 1'b1;
        wait_cfg_done("cfg_req_done");
        drain("cfg_req_drain");
        TXRDY = 1'b0;
        step(2);

        // ---- 6: reset during ACCESS of the high-byte write ----
        expect_ev(EV_WR, 2'd0, 8'hEF);
        cfg_req = 1'b1;
        cfg_div = 16'hBEEF;
        step(1);
        cfg_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (PSEL && !PENABLE && PADDR == 2'd1) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        check("rst_mid_found_setup", {31'd0, seen}, 1);
        PREADY = 1'b0;
        step(2);
        check("rst_mid_in_access", {31'd0, PENABLE}, 1);
        #2;
        PRESET = 1'b1;
        #1;
        check("rst_mid_psel",     {31'd0, PSEL},     0);
        check("rst_mid_penable",  {31'd0, PENABLE},  0);
        check("rst_mid_cfg_done", {31'd0, cfg_done}, 0);
        expect_ev(EV_WR, 2'd0, 8'h0D);
        expect_ev(EV_WR, 2'd1, 8'h00);
        PREADY = 1'b1;
        step(2);
        PRESET = 1'b0;
        wait_cfg_done("rst_mid_cfg_done_again");
        drain("rst_mid_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
